// File: rtl/nixie_pkg.sv
// Shared constants, frame/cathode types and serializer state encoding for the nixie frame path.
package nixie_pkg;

    localparam int NUM_TUBES     = 6;
    localparam int CATH_PER_TUBE = 12;
    localparam int FRAME_BITS    = 72;
    localparam int BCD_W         = 4;
    localparam int DP_L_IDX      = 10;
    localparam int DP_R_IDX      = 11;

    typedef logic [FRAME_BITS-1:0]    frame_t;
    typedef logic [CATH_PER_TUBE-1:0] cath_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LO,
        HI,
        DONE
    } state_t;

endpackage

// File: rtl/nixie_digit_decoder.sv
// One tube: BCD + decimal points -> 12-bit one-hot cathode word; purely combinational, no backpressure.
// BCD 10-15 or blank lights no digit cathode; dp bits always pass through.
module nixie_digit_decoder
    import nixie_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic             dp_l,
    input  logic             dp_r,
    input  logic             blank,
    output cath_t            cath
);

    always_comb begin
        cath = '0;
        if (!blank && (bcd < 4'd10)) begin
            cath[bcd] = 1'b1;
        end
        cath[DP_L_IDX] = dp_l;
        cath[DP_R_IDX] = dp_r;
    end

endmodule

// File: rtl/nixie_frame_serializer.sv
// Serializes a 72-bit cathode frame MSB first into the CPLD shifter (done 145*CLK_DIV cycles after busy); load ignored while busy.
// Also drives the free-running bank-mix pwm; NIXIE_BLANK_LEADING_ZERO_EN enables leading-zero blanking.
module nixie_frame_serializer
    import nixie_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          bank,
    input  logic [NUM_TUBES*BCD_W-1:0]    digits,
    input  logic [NUM_TUBES-1:0]          dp_l,
    input  logic [NUM_TUBES-1:0]          dp_r,
    input  logic [PWM_BITS-1:0]           duty,
    output logic                          busy,
    output logic                          done,
    output logic                          sclk,
    output logic                          sdata,
    output logic                          ssel,
    output logic                          pwm
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    frame_t                shreg;
    frame_t                frame_new;
    logic                  bank_q;
    logic [NUM_TUBES-1:0]  blank;
    logic                  tick;
    logic                  accept;
    logic [PWM_BITS-1:0]   cnt;
    logic [PWM_BITS-1:0]   duty_q;

`ifdef NIXIE_BLANK_LEADING_ZERO_EN
    // Blanking propagates downward from tube 5 while tubes read zero; tube 0 always shows.
    logic lead;
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int t = NUM_TUBES - 1; t > 0; t--) begin
            lead     = lead && (digits[BCD_W*t +: BCD_W] == 4'd0);
            blank[t] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < NUM_TUBES; g++) begin : g_tube
        nixie_digit_decoder u_dec (
            .bcd   (digits[BCD_W*g +: BCD_W]),
            .dp_l  (dp_l[g]),
            .dp_r  (dp_r[g]),
            .blank (blank[g]),
            .cath  (frame_new[CATH_PER_TUBE*g +: CATH_PER_TUBE])
        );
    end

    assign tick   = (div_cnt == DIV_LAST);
    assign accept = (state_q == IDLE) && load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        sclk    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (load) state_d = SETUP;
            end
            SETUP: begin
                if (tick) state_d = LO;
            end
            LO: begin
                if (tick) state_d = HI;
            end
            HI: begin
                sclk = 1'b1;
                if (tick) state_d = (bit_cnt == BIT_LAST) ? DONE : LO;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            bank_q  <= 1'b0;
        end else begin
            if ((state_d != state_q) || (state_q == IDLE)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (accept) begin
                shreg   <= frame_new;
                bank_q  <= bank;
                bit_cnt <= '0;
            end else if ((state_q == HI) && tick) begin
                bit_cnt <= bit_cnt + 1'b1;
                // The last bit stays on sdata; no shift past the end of the frame.
                if (bit_cnt != BIT_LAST) begin
                    shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign sdata = shreg[FRAME_BITS-1];
    assign ssel  = bank_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            duty_q <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
                duty_q <= duty;
            end
        end
    end

    assign pwm = (cnt < duty_q);

endmodule

// File: tb/tb_nixie_frame_serializer.sv
// Randomized self-checking bench for nixie_frame_serializer with a frame-level receiver model.
module tb_nixie_frame_serializer;

    localparam int CLK_DIV_TB = 2;
    localparam int DONE_AT    = 145 * CLK_DIV_TB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        bank = 1'b0;
    logic [23:0] digits = '0;
    logic [5:0]  dp_l = '0;
    logic [5:0]  dp_r = '0;
    logic [7:0]  duty = '0;
    logic        busy, done, sclk, sdata, ssel, pwm;

    int checks = 0;
    int failures = 0;

    nixie_frame_serializer #(.CLK_DIV(CLK_DIV_TB), .PWM_BITS(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .bank   (bank),
        .digits (digits),
        .dp_l   (dp_l),
        .dp_r   (dp_r),
        .duty   (duty),
        .busy   (busy),
        .done   (done),
        .sclk   (sclk),
        .sdata  (sdata),
        .ssel   (ssel),
        .pwm    (pwm)
    );

    always #5 clk = ~clk;

    // Receiver: two 72-bit left-shift banks, as in the CPLD stage.
    logic [71:0] rx1 = '0;
    logic [71:0] rx2 = '0;
    int          rises = 0;
    always @(posedge sclk) begin
        rises <= rises + 1;
        if (ssel) rx1 <= {rx1[70:0], sdata};
        else      rx2 <= {rx2[70:0], sdata};
    end

    // Cycles since reset release; pwm counter phase is this value mod 256.
    int tb_cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    function automatic logic [71:0] build_frame(input logic [23:0] dg, input logic [5:0] l,
                                                input logic [5:0] r);
        logic [71:0] f;
        logic        lead;
        logic [3:0]  d;
        f = '0;
`ifdef NIXIE_BLANK_LEADING_ZERO_EN
        lead = 1'b1;
`else
        lead = 1'b0;
`endif
        for (int t = 5; t >= 0; t--) begin
            d = dg[4*t +: 4];
            if (d != 4'd0) lead = 1'b0;
            if ((d < 4'd10) && !(lead && (t != 0))) f[12*t + int'(d)] = 1'b1;
            f[12*t + 10] = l[t];
            f[12*t + 11] = r[t];
        end
        return f;
    endfunction

    int   obs_cyc, obs_dones, obs_rises;
    logic obs_busy1, obs_sel1, obs_busy_later;
    bit   obs_timeout;

    task automatic run_frame(input logic [23:0] dg, input logic [5:0] l, input logic [5:0] r,
                             input logic bk, input bit disturb, input bit load_at_done);
        int r0;
        digits = dg; dp_l = l; dp_r = r; bank = bk; load = 1'b1;
        r0 = rises;
        obs_dones = 0; obs_cyc = -1; obs_timeout = 1'b1; obs_busy_later = 1'b0;
        @(posedge clk); #1;
        load = 1'b0;
        obs_busy1 = busy;
        obs_sel1  = ssel;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            load = 1'b0;
            if (disturb && c == 100) begin
                digits = ~dg; dp_l = ~l; dp_r = ~r; bank = ~bk; load = 1'b1;
            end
            if (done) begin
                obs_dones++;
                if (obs_cyc < 0) obs_cyc = c;
                if (load_at_done) load = 1'b1;
            end
            if (!busy && obs_dones > 0) begin
                obs_timeout = 1'b0;
                break;
            end
        end
        load = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (busy) obs_busy_later = 1'b1;
            if (done) obs_dones++;
        end
        obs_rises = rises - r0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sclk !== 1'b0)  begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (sdata !== 1'b0) begin failures++; $display("FAIL reset_sdata got=%b exp=0", sdata); end
        checks++; if (ssel !== 1'b0)  begin failures++; $display("FAIL reset_ssel got=%b exp=0", ssel); end
        checks++; if (pwm !== 1'b0)   begin failures++; $display("FAIL reset_pwm got=%b exp=0", pwm); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [71:0] exp;
        exp = '0;
        exp[12*5+1] = 1'b1; exp[12*4+2] = 1'b1; exp[12*3+3] = 1'b1;
        exp[12*2+4] = 1'b1; exp[12*1+5] = 1'b1; exp[12*0+6] = 1'b1;
        run_frame(24'h123456, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (obs_timeout) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
        checks++; if (obs_busy1 !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b exp=1", obs_busy1); end
        checks++; if (obs_sel1 !== 1'b1) begin failures++; $display("FAIL basic_ssel got=%b exp=1", obs_sel1); end
        checks++; if (obs_cyc != DONE_AT) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", obs_cyc, DONE_AT); end
        checks++; if (obs_rises != 72) begin failures++; $display("FAIL basic_sclk_rises got=%0d exp=72", obs_rises); end
        checks++; if (obs_dones != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", obs_dones); end
        checks++; if (rx1 !== exp) begin failures++; $display("FAIL basic_frame got=%h exp=%h", rx1, exp); end
        checks++; if (ssel !== 1'b1) begin failures++; $display("FAIL basic_ssel_idle got=%b exp=1", ssel); end
        checks++; if (obs_busy_later !== 1'b0) begin failures++; $display("FAIL basic_busy_idle got=%b exp=0", obs_busy_later); end
    endtask

    task automatic test_dp_only();
        logic [71:0] exp;
        exp = '0;
        for (int t = 0; t < 6; t++) exp[12*t + 10] = 1'b1;
        run_frame(24'hFFFFFF, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_timeout) begin failures++; $display("FAIL dp_timeout got=timeout exp=done"); end
        checks++; if (obs_sel1 !== 1'b0) begin failures++; $display("FAIL dp_ssel got=%b exp=0", obs_sel1); end
        checks++; if (rx2 !== exp) begin failures++; $display("FAIL dp_frame got=%h exp=%h", rx2, exp); end
        checks++; if (obs_rises != 72) begin failures++; $display("FAIL dp_sclk_rises got=%0d exp=72", obs_rises); end
    endtask

    task automatic test_random_frames();
        logic [23:0] dg; logic [5:0] l, r; logic bk; logic [71:0] got;
        for (int i = 0; i < 5; i++) begin
            dg = 24'($urandom); l = 6'($urandom); r = 6'($urandom); bk = 1'($urandom);
            run_frame(dg, l, r, bk, 1'b0, 1'b0);
            got = bk ? rx1 : rx2;
            checks++; if (got !== build_frame(dg, l, r)) begin failures++; $display("FAIL rand_frame%0d got=%h exp=%h", i, got, build_frame(dg, l, r)); end
            checks++; if (obs_cyc != DONE_AT) begin failures++; $display("FAIL rand_done_cycle%0d got=%0d exp=%0d", i, obs_cyc, DONE_AT); end
        end
    endtask

    task automatic test_load_ignored();
        logic [23:0] dg; logic [5:0] l, r; logic bk; logic [71:0] got;
        dg = 24'($urandom); l = 6'($urandom); r = 6'($urandom); bk = 1'($urandom);
        run_frame(dg, l, r, bk, 1'b1, 1'b0);
        got = bk ? rx1 : rx2;
        checks++; if (got !== build_frame(dg, l, r)) begin failures++; $display("FAIL busy_load_frame got=%h exp=%h", got, build_frame(dg, l, r)); end
        checks++; if (obs_dones != 1) begin failures++; $display("FAIL busy_load_dones got=%0d exp=1", obs_dones); end
        checks++; if (obs_rises != 72) begin failures++; $display("FAIL busy_load_rises got=%0d exp=72", obs_rises); end
        checks++; if (ssel !== bk) begin failures++; $display("FAIL busy_load_ssel got=%b exp=%b", ssel, bk); end
    endtask

    task automatic test_load_at_done();
        run_frame(24'h987654, 6'h01, 6'h20, 1'b1, 1'b0, 1'b1);
        checks++; if (obs_busy_later !== 1'b0) begin failures++; $display("FAIL done_load_busy got=%b exp=0", obs_busy_later); end
        checks++; if (obs_dones != 1) begin failures++; $display("FAIL done_load_dones got=%0d exp=1", obs_dones); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] dg; logic [5:0] l, r; logic [71:0] got; int r0; bit reached;
        digits = 24'($urandom); dp_l = '0; dp_r = '0; bank = 1'b1; load = 1'b1;
        r0 = rises; reached = 1'b0;
        @(posedge clk); #1; load = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (rises - r0 >= 30) begin reached = 1'b1; break; end
        end
        checks++; if (!reached) begin failures++; $display("FAIL midrst_reach got=timeout exp=30 rises"); end
        rst = 1'b1;
        #1;
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL midrst_sclk got=%b exp=0", sclk); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (ssel !== 1'b0) begin failures++; $display("FAIL midrst_ssel got=%b exp=0", ssel); end
        checks++; if (sdata !== 1'b0) begin failures++; $display("FAIL midrst_sdata got=%b exp=0", sdata); end
        #3 rst = 1'b0;
        @(posedge clk); #1;
        dg = 24'($urandom); l = 6'($urandom); r = 6'($urandom);
        run_frame(dg, l, r, 1'b1, 1'b0, 1'b0);
        got = rx1;
        checks++; if (got !== build_frame(dg, l, r)) begin failures++; $display("FAIL midrst_frame got=%h exp=%h", got, build_frame(dg, l, r)); end
        checks++; if (obs_rises != 72) begin failures++; $display("FAIL midrst_rises got=%0d exp=72", obs_rises); end
    endtask

    task automatic test_blank();
        logic [71:0] exp;
        exp = '0; exp[0] = 1'b1; exp[14] = 1'b1; exp[25] = 1'b1;
`ifndef NIXIE_BLANK_LEADING_ZERO_EN
        exp[36] = 1'b1; exp[48] = 1'b1; exp[60] = 1'b1;
`endif
        run_frame(24'h000120, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (rx1 !== exp) begin failures++; $display("FAIL blank_000120 got=%h exp=%h", rx1, exp); end
        exp = '0; exp[0] = 1'b1;
`ifndef NIXIE_BLANK_LEADING_ZERO_EN
        exp[12] = 1'b1; exp[24] = 1'b1; exp[36] = 1'b1; exp[48] = 1'b1; exp[60] = 1'b1;
`endif
        run_frame(24'h000000, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (rx2 !== exp) begin failures++; $display("FAIL blank_000000 got=%h exp=%h", rx2, exp); end
    endtask

    bit pwm_timeout;

    task automatic wait_phase(input int p);
        for (int i = 0; i < 600; i++) begin
            if ((tb_cyc % 256) == p) return;
            @(posedge clk); #1;
        end
        pwm_timeout = 1'b1;
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm) h++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pwm();
        int h;
        pwm_timeout = 1'b0;
        wait_phase(10);
        duty = 8'd64;
        wait_phase(0);
        count_high(256, h);
        checks++; if (h != 64) begin failures++; $display("FAIL pwm_duty64 got=%0d exp=64", h); end
        count_high(100, h);
        checks++; if (h != 64) begin failures++; $display("FAIL pwm_head64 got=%0d exp=64", h); end
        duty = 8'd200;
        count_high(156, h);
        checks++; if (h != 0) begin failures++; $display("FAIL pwm_midchange got=%0d exp=0", h); end
        count_high(256, h);
        checks++; if (h != 200) begin failures++; $display("FAIL pwm_duty200 got=%0d exp=200", h); end
        duty = 8'd0;
        count_high(256, h);
        checks++; if (h != 200) begin failures++; $display("FAIL pwm_latch_hold got=%0d exp=200", h); end
        duty = 8'd255;
        count_high(256, h);
        checks++; if (h != 0) begin failures++; $display("FAIL pwm_duty0 got=%0d exp=0", h); end
        count_high(256, h);
        checks++; if (h != 255) begin failures++; $display("FAIL pwm_duty255 got=%0d exp=255", h); end
        checks++; if (pwm_timeout) begin failures++; $display("FAIL pwm_phase_wait got=timeout exp=phase"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dp_only();
        test_random_frames();
        test_load_ignored();
        test_load_at_done();
        test_reset_mid();
        test_blank();
        test_pwm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
